// File: rtl/alu_pkg.sv
// Shared encodings and constants for the EX-stage divider.
package alu_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NEG_A = 3'd1,
    NEG_B = 3'd2,
    ITER  = 3'd3,
    FIX   = 3'd4
  } state_t;

  // op[0]=0 selects the signed variants (DIV, REM).
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div32_iter_if.sv
// Request/response bundle between the EX stage and the divider.
interface div32_iter_if;
  import alu_pkg::*;

  // start is taken only while idle; done pulses for one cycle with result
  // valid in that same cycle; busy stays high from the cycle after an
  // accepted start until the cycle that carries done.
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  state_t      state;

  modport master (output start, op, a, b, kill,
                  input  busy, done, result, state);
  modport slave  (input  start, op, a, b, kill,
                  output busy, done, result, state);

endinterface

// File: rtl/adder32.sv
// 32-bit adder: 4-bit carry-lookahead groups chained group to group.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);

  for (genvar i = 0; i < 8; i++) begin : g_blk
    logic [3:0] gg;
    logic [3:0] pp;
    logic       cin;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       cout;

    assign gg = a[4*i +: 4] & b[4*i +: 4];
    assign pp = a[4*i +: 4] ^ b[4*i +: 4];

    if (i == 0) begin : g_first
      assign cin = ci;
    end else begin : g_chain
      assign cin = g_blk[i-1].cout;
    end

    assign c1   = gg[0] | (pp[0] & cin);
    assign c2   = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
    assign c3   = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & cin);
    assign cout = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & cin);

    assign sum[4*i +: 4] = pp ^ {c3, c2, c1, cin};
  end

  assign co = g_blk[7].cout;

endmodule

// File: rtl/div32_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module div32_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  div32_iter_if.slave   bus
);

  state_t            state;
  state_t            state_nxt;

  logic              sgn_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic              rem_sel_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvs;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              b_zero;
  logic              ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   sub_sum;
  logic              sub_co;
  logic              qbit;

  logic [XLEN-1:0]   neg_in;
  logic [XLEN-1:0]   neg_sum;
  logic              neg_co;
  logic [XLEN-1:0]   fix_sel;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_val;

  assign b_zero      = (bus.b == '0);
  assign ovf         = is_signed_op(bus.op) && (bus.a == INT_MIN) && (bus.b == ALL_ONES);
  assign special     = b_zero || ovf;
  assign special_res = b_zero ? (bus.op[1] ? bus.a : ALL_ONES)
                              : (bus.op[1] ? '0    : INT_MIN);

  // A set rem[31] means the shifted remainder is really 33 bits wide and
  // therefore always exceeds the divisor.
  assign sh   = {rem[XLEN-2:0], quo[XLEN-1]};
  assign qbit = rem[XLEN-1] | sub_co;

  adder32 u_sub (
    .a   (sh),
    .b   (~dvs),
    .ci  (1'b1),
    .sum (sub_sum),
    .co  (sub_co)
  );

  assign fix_sel = rem_sel_q ? rem : quo;
  assign fix_neg = sgn_q && (rem_sel_q ? neg_a_q : (neg_a_q ^ neg_b_q));

  always_comb begin
    neg_in = fix_sel;
    case (state)
      NEG_A:   neg_in = a_q;
      NEG_B:   neg_in = b_q;
      default: neg_in = fix_sel;
    endcase
  end

  adder32 u_neg (
    .a   (~neg_in),
    .b   ('0),
    .ci  (1'b1),
    .sum (neg_sum),
    .co  (neg_co)
  );

  // neg_co flags a zero operand, whose negation is itself.
  assign fix_val = (fix_neg && !neg_co) ? neg_sum : fix_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start && !special) state_nxt = NEG_A;
        NEG_A:   state_nxt = NEG_B;
        NEG_B:   state_nxt = ITER;
        ITER:    if (cnt == 5'd31) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.kill) begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (special) begin
                result_q <= special_res;
                done_q   <= 1'b1;
              end else begin
                sgn_q     <= is_signed_op(bus.op);
                neg_a_q   <= bus.a[XLEN-1];
                neg_b_q   <= bus.b[XLEN-1];
                rem_sel_q <= bus.op[1];
                a_q       <= bus.a;
                b_q       <= bus.b;
              end
            end
          end
          NEG_A: quo <= (sgn_q && neg_a_q) ? neg_sum : a_q;
          NEG_B: begin
            dvs <= (sgn_q && neg_b_q) ? neg_sum : b_q;
            rem <= '0;
            cnt <= '0;
          end
          ITER: begin
            rem <= qbit ? sub_sum : sh;
            quo <= {quo[XLEN-2:0], qbit};
            cnt <= cnt + 5'd1;
          end
          FIX: begin
            result_q <= fix_val;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_div32_iter.sv
// Directed-vector bench for div32_iter: latency, results, specials, kill, reset.
module tb_div32_iter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div32_iter_if bus ();

  div32_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one op; exp_edge is the number of clock edges after the sampling
  // edge until done shows up (0 for special cases, 35 for full divides).
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_edge, input int poke_at);
    int          k;
    int          busy_cycles;
    logic [31:0] exp;
    exp_q.push_back(exp_res);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
    k = 0;
    busy_cycles = 0;
    while (!bus.done && k < 60) begin
      if (bus.busy) busy_cycles++;
      if (poke_at >= 0 && k == poke_at) begin
        bus.start = 1'b1;
        bus.op    = DIVU_OP;
        bus.a     = 32'd1000;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    check({tag, "_edge"}, 32'(k), 32'(exp_edge));
    check({tag, "_busy"}, 32'(busy_cycles), 32'(exp_edge));
    exp = exp_q.pop_front();
    check({tag, "_res"}, bus.result, exp);
    last_res = exp;
    @(posedge clk); #1;
    check({tag, "_done_low"}, {31'b0, bus.done}, 32'h0);
  endtask

  initial begin
    int done_seen;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.kill  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy",   {31'b0, bus.busy}, 32'h0);
    check("rst_done",   {31'b0, bus.done}, 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_state",  32'(bus.state), 32'(IDLE));
    rst_n = 1'b1;

    run_op("divu_100_7",  DIVU_OP, 32'd100, 32'd7, 32'd14, 35, -1);
    run_op("remu_100_7",  REMU_OP, 32'd100, 32'd7, 32'd2,  35, -1);
    run_op("div_m100_7",  DIV_OP,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35, -1);
    run_op("rem_m100_7",  REM_OP,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 35, -1);
    run_op("div_100_m7",  DIV_OP,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 35, -1);
    run_op("rem_100_m7",  REM_OP,  32'd100, 32'hFFFF_FFF9, 32'd2, 35, -1);
    run_op("div_min_2",   DIV_OP,  32'h8000_0000, 32'd2, 32'hC000_0000, 35, -1);
    run_op("div_5_0",     DIV_OP,  32'd5, 32'd0, 32'hFFFF_FFFF, 0, -1);
    run_op("remu_5_0",    REMU_OP, 32'd5, 32'd0, 32'd5, 0, -1);
    run_op("div_ovf",     DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, -1);
    run_op("rem_ovf",     REM_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, -1);
    run_op("divu_max_1",  DIVU_OP, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, -1);
    run_op("divu_max_hi", DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 35, -1);
    run_op("remu_max_hi", REMU_OP, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 35, -1);
    run_op("busy_start",  DIVU_OP, 32'd100, 32'd7, 32'd14, 35, 5);

    // Kill while ITER is on its cnt=10 step.
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU_OP; bus.a = 32'd500; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("kill_pre_state", 32'(bus.state), 32'(ITER));
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill_busy",  {31'b0, bus.busy}, 32'h0);
    check("kill_state", 32'(bus.state), 32'(IDLE));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      @(posedge clk); #1;
    end
    check("kill_no_done", 32'(done_seen), 32'h0);
    check("kill_result",  bus.result, last_res);
    run_op("after_kill", DIVU_OP, 32'd500, 32'd3, 32'd166, 35, -1);

    // kill beats start in IDLE, even for a special case.
    @(negedge clk);
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = DIV_OP; bus.a = 32'd9; bus.b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    check("kill_start_done", {31'b0, bus.done}, 32'h0);
    check("kill_start_busy", {31'b0, bus.busy}, 32'h0);
    check("kill_start_res",  bus.result, last_res);

    // Asynchronous reset in the middle of ITER.
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU_OP; bus.a = 32'd77; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   {31'b0, bus.busy}, 32'h0);
    check("mid_rst_done",   {31'b0, bus.done}, 32'h0);
    check("mid_rst_result", bus.result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'h0);
    run_op("after_rst", REMU_OP, 32'd77, 32'd5, 32'd2, 35, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
